// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad column scanner with press/release debounce and a
// one-entry valid/ack key buffer. Define KEYPAD_AUTOREPEAT_EN to re-emit a held key periodically.
module keypad_scan_ctrl #(
    parameter int unsigned CLK_DIV        = 100000,
    parameter int unsigned DEBOUNCE_TICKS = 10,
    parameter int unsigned REPEAT_TICKS   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keyin,
    output logic [3:0] keyout,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       overrun
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    if (CLK_DIV < 2 || DEBOUNCE_TICKS == 0 || REPEAT_TICKS == 0) begin : g_param_check
        $error("keypad_scan_ctrl: illegal parameter value");
    end

    logic [1:0]       state, state_d;
    logic [DIV_W-1:0] div_cnt, div_cnt_d;
    logic [DB_W-1:0]  db_cnt, db_cnt_d, db_inc;
    logic [7:0]       pat, pat_d;
    logic [3:0]       keyout_d, key_code_d, pat_code;
    logic             key_valid_d, key_held_d, overrun_d;
    logic             tick, emit, row_one_cold;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_TICKS + 1);
    logic [REP_W-1:0] rep_cnt, rep_cnt_d, rep_inc;
    assign rep_inc = rep_cnt + REP_W'(1);
`endif

    // Position of the single low bit counted from the MSB; the key map is this pair of positions
    function automatic logic [1:0] cold_pos(input logic [3:0] v);
        case (v)
            4'b0111: cold_pos = 2'd0;
            4'b1011: cold_pos = 2'd1;
            4'b1101: cold_pos = 2'd2;
            default: cold_pos = 2'd3;
        endcase
    endfunction

    assign tick         = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign db_inc       = db_cnt + DB_W'(1);
    assign pat_code     = {cold_pos(pat[7:4]), cold_pos(pat[3:0])};
    assign row_one_cold = keyin inside {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        div_cnt_d   = tick ? '0 : div_cnt + DIV_W'(1);
        db_cnt_d    = db_cnt;
        pat_d       = pat;
        keyout_d    = keyout;
        key_held_d  = key_held;
        key_code_d  = key_code;
        key_valid_d = key_valid;
        overrun_d   = overrun;
        emit        = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt;
`endif
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (row_one_cold) begin
                        pat_d    = {keyout, keyin};
                        db_cnt_d = '0;
                        state_d  = ST_DEBOUNCE;
                    end else begin
                        keyout_d = {keyout[2:0], keyout[3]};
                    end
                end
                ST_DEBOUNCE: begin
                    if (keyin == pat[3:0]) begin
                        if (db_inc == DB_W'(DEBOUNCE_TICKS)) begin
                            emit       = 1'b1;
                            key_held_d = 1'b1;
                            db_cnt_d   = '0;
                            state_d    = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt_d  = '0;
`endif
                        end else begin
                            db_cnt_d = db_inc;
                        end
                    end else begin
                        db_cnt_d = '0;
                        state_d  = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (keyin == 4'b1111) begin
                        if (db_inc == DB_W'(DEBOUNCE_TICKS)) begin
                            key_held_d = 1'b0;
                            db_cnt_d   = '0;
                            state_d    = ST_SCAN;
                        end else begin
                            db_cnt_d = db_inc;
                        end
                    end else begin
                        db_cnt_d = '0;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (keyin == pat[3:0]) begin
                        if (rep_inc == REP_W'(REPEAT_TICKS)) begin
                            emit      = 1'b1;
                            rep_cnt_d = '0;
                        end else begin
                            rep_cnt_d = rep_inc;
                        end
                    end else begin
                        rep_cnt_d = '0;
                    end
`endif
                end
                default: state_d = ST_SCAN;
            endcase
        end

        // Ack consumes the buffer; a same-cycle emit reloads it without flagging overrun
        if (key_valid && key_ack) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (emit) begin
            key_code_d  = pat_code;
            key_valid_d = 1'b1;
            if (key_valid && !key_ack) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_SCAN;
            div_cnt   <= '0;
            db_cnt    <= '0;
            pat       <= '0;
            keyout    <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            overrun   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            state     <= state_d;
            div_cnt   <= div_cnt_d;
            db_cnt    <= db_cnt_d;
            pat       <= pat_d;
            keyout    <= keyout_d;
            key_code  <= key_code_d;
            key_valid <= key_valid_d;
            key_held  <= key_held_d;
            overrun   <= overrun_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= rep_cnt_d;
`endif
        end
    end

endmodule
